trace_tx: RTL and testbench
===========================

Name: trace_tx

Overview:
- Transmit-side counterpart of the trace capture path. Serialises pre-formatted 16-byte trace frames onto a 1/2/4-bit DDR trace port with a forwarded trace clock.
- Inserts TPIU full-sync (0x7FFFFFFF) and halfword-sync (0x7FFF) patterns so the receive path can lock and stay locked.
- Used as the on-chip trace source for loopback and self-test of the capture chain, and as the stimulus generator in system benches.

Parameters:
- SYNC_INTERVAL, 64: frames between automatic full syncs; 0 means full sync only after reset or on syncReq.
- CNT_W, 8: width of the frame counter; must satisfy 2^CNT_W > SYNC_INTERVAL.

Ports:
- clk  input  1  system clock; one trace nibble-slot per cycle.
- rst  input  1  reset; asynchronous assert, active-low.
- width  input  2  port width: 0=1 bit, 1=2 bits, 2 or 3=4 bits. Sampled only at full-sync start.
- syncReq  input  1  pulse; requests a full sync at the next frame boundary.
- PacketWd  input  16  next frame halfword, little-endian: byte n in [7:0], byte n+1 in [15:8].
- WdAvail  input  1  PacketWd is valid.
- WdTaken  output  1  PacketWd consumed this cycle; a transfer occurs when WdAvail and WdTaken are both high.
- traceDout  output  4  trace data pins; bits at and above the active width are driven 0.
- traceClkOut  output  1  forwarded trace clock; toggles every clk cycle.
- inFrame  output  1  high while frame halfwords are being shifted out.
- underrun  output  1  one-cycle pulse when a mid-frame slot had no data.

Behaviour:
- Reset values: traceDout=0, traceClkOut=0, WdTaken=0, inFrame=0, underrun=0, frame counter=0, syncReq latch=0, latched width=4 bits.
- First cycle after rst deasserts: enter FSYNC.
- All outputs are registered.
- traceClkOut toggles every cycle; one nibble-slot per clk. The receiver's DDR capture samples slot k on the traceClkOut edge produced with slot k+1.
- Serialisation: each 16-bit pattern is shifted out LSB-first, w bits per cycle on traceDout[w-1:0].
  - 16/w cycles per halfword: 16, 8 or 4.
  - 32-bit full sync takes 2x that.
- Widths: width sampled at FSYNC entry only. A change elsewhere takes effect at the next full sync.
- States:
  - FSYNC: shift 0x7FFFFFFF (31 ones, then a zero). On completion, clear the frame counter and the syncReq latch, then go to BOUNDARY decision.
  - HSYNC: shift 0x7FFF, then BOUNDARY decision.
  - FRAME: shift 8 halfwords (16 bytes) taken from PacketWd. After the 8th, increment the frame counter, then BOUNDARY decision.
- BOUNDARY decision (combinational, taken in the last slot of the current pattern, so no idle gap):
  - if syncReq latched, or (SYNC_INTERVAL!=0 and counter==SYNC_INTERVAL): FSYNC;
  - else if WdAvail: FRAME;
  - else: HSYNC.
- Handshake: WdTaken is asserted only in the last slot of a pattern whose successor is a FRAME halfword and only when WdAvail=1. The word loads into the shifter the next cycle.
  - No combinational path from WdAvail to WdTaken beyond this one AND.
- syncReq: latched whenever high. Pulses arriving during FSYNC are absorbed by that sync, so the latch clears at FSYNC end.
- Mid-frame starvation: if WdAvail=0 when a frame halfword is due, insert one 0x7FFF slot and pulse underrun.
  - The inserted slot does not count toward the 8 halfwords.
  - Retry at the end of the inserted halfword.
- inFrame: high from the first to the last slot of frame data; low during syncs and insertions.
- Frame counter saturates at SYNC_INTERVAL; it does not wrap while a frame is pending.
- Async reset mid-pattern: the pattern is abandoned immediately, all outputs take reset values, and the block restarts with FSYNC. A word held but not yet fully shifted is lost.

Test Plan:
- Reset release, width=2 (4-bit), WdAvail=0 -> traceDout nibbles F,F,F,F,F,F,F,7 (8 cycles); then repeating F,F,F,7 halfword syncs; traceClkOut toggles every cycle; WdTaken stays 0.
- Width 4-bit, after FSYNC supply 8 words 0x3412,0x7856,... back-to-back -> nibbles 2,1,4,3,6,5,8,7,...; exactly 8 WdTaken pulses; inFrame high 32 cycles; no gap between sync and first data nibble.
- Width=0 (1-bit) single frame word 0x0001 -> traceDout[0] sequence 1 followed by 15 zeros; traceDout[3:1]=0 throughout; halfword occupies 16 cycles.
- Drop WdAvail after 3 words of a frame -> one 0x7FFF halfword inserted (F,F,F,7), underrun pulses once, frame resumes with word 4; exactly 8 data halfwords in total.
- SYNC_INTERVAL=2, continuous data -> full sync appears after every 2 frames; a syncReq pulse mid-frame yields a full sync at that frame's end; a syncReq pulse during FSYNC causes no extra sync.
- Assert rst mid-frame at slot 5, release -> outputs reset the same cycle asynchronously; the next pattern is a complete FSYNC using the current width input.

Source files
------------

// File: rtl/trace_tx_if.sv
// Frame-word handshake between a frame source and the trace transmitter.
// The source offers PacketWd/WdAvail; the transmitter consumes with WdTaken.
interface trace_tx_if;
    logic [15:0] PacketWd;
    logic        WdAvail;
    logic        WdTaken;

    modport master (output PacketWd, output WdAvail, input WdTaken);
    modport slave  (input PacketWd, input WdAvail, output WdTaken);
endinterface

// File: rtl/trace_tx.sv
// Trace port transmitter: serialises 16-byte frames onto a 1/2/4-bit trace port,
// inserting TPIU full/halfword syncs and forwarding a toggling trace clock.
module trace_tx #(
    parameter int unsigned SYNC_INTERVAL = 64,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] width,
    input  logic       syncReq,
    trace_tx_if.slave  wd,
    output logic [3:0] traceDout,
    output logic       traceClkOut,
    output logic       inFrame,
    output logic       underrun
);
    localparam int unsigned SLOT_W = 5;
    localparam int unsigned HW_W   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX =
        (SYNC_INTERVAL == 0) ? {CNT_W{1'b1}} : CNT_W'(SYNC_INTERVAL);
    localparam logic [31:0] FSYNC_PAT = 32'h7FFF_FFFF;
    localparam logic [31:0] HSYNC_PAT = 32'h0000_7FFF;

    typedef enum logic [2:0] {S_IDLE, S_FSYNC, S_HSYNC, S_FRAME, S_INS} state_t;

    state_t            st_q, st_d;
    logic [31:0]       sh_q, sh_d, pat;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [5:0]        nslots;
    logic [HW_W-1:0]   hw_q, hw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              latch_q, latch_d;
    logic              offer_q, offer_d;
    logic [1:0]        wsel_q, wsel_d;
    logic [3:0]        dout_d;
    logic              last, mid, mid_d, sync_due;

    // wsel encodes bits per slot as 1 << wsel
    function automatic logic [1:0] wsel_of(input logic [1:0] w);
        return (w == 2'd0) ? 2'd0 : ((w == 2'd1) ? 2'd1 : 2'd2);
    endfunction

    function automatic logic [3:0] slot_bits(input logic [31:0] d, input logic [1:0] ws);
        case (ws)
            2'd0:    return {3'b000, d[0]};
            2'd1:    return {2'b00, d[1:0]};
            default: return d[3:0];
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic sync_hit(input logic [CNT_W-1:0] c);
        return (SYNC_INTERVAL != 0) && (c == CNT_W'(SYNC_INTERVAL));
    endfunction

    // Pattern sequencing: the successor is chosen in the last slot so patterns abut
    always_comb begin
        st_d     = st_q;
        sh_d     = sh_q;
        slot_d   = slot_q;
        hw_d     = hw_q;
        cnt_d    = cnt_q;
        wsel_d   = wsel_q;
        latch_d  = latch_q | syncReq;
        pat      = '0;
        nslots   = '0;
        dout_d   = '0;
        sync_due = 1'b0;
        last     = (st_q == S_IDLE) || (slot_q == '0);
        mid      = ((st_q == S_FRAME) && (hw_q != 3'd7)) || (st_q == S_INS);

        if (last) begin
            if (st_q == S_FSYNC) begin
                cnt_d   = '0;
                latch_d = 1'b0;
            end
            if ((st_q == S_FRAME) && !mid) cnt_d = cnt_inc(cnt_q);

            if (st_q == S_IDLE)                st_d = S_FSYNC;
            else if (offer_q && wd.WdAvail)    st_d = S_FRAME;
            else if (mid)                      st_d = S_INS;
            else if (offer_q)                  st_d = S_HSYNC;
            else                               st_d = S_FSYNC;

            if (st_d == S_FRAME) hw_d = mid ? hw_q + HW_W'(1) : '0;
            if (st_d == S_FSYNC) wsel_d = wsel_of(width);

            case (st_d)
                S_FSYNC: pat = FSYNC_PAT;
                S_FRAME: pat = {16'h0000, wd.PacketWd};
                default: pat = HSYNC_PAT;
            endcase
            nslots = ((st_d == S_FSYNC) ? 6'd32 : 6'd16) >> wsel_d;
            slot_d = SLOT_W'(nslots - 6'd1);
            dout_d = slot_bits(pat, wsel_d);
            sh_d   = pat >> (3'd1 << wsel_d);
        end else begin
            slot_d = slot_q - SLOT_W'(1);
            dout_d = slot_bits(sh_q, wsel_q);
            sh_d   = sh_q >> (3'd1 << wsel_q);
        end

        // Registered permission to take a word in the coming last slot
        mid_d = ((st_d == S_FRAME) && (hw_d != 3'd7)) || (st_d == S_INS);
        if ((st_d == S_FSYNC) || mid_d) sync_due = 1'b0;
        else if (st_d == S_FRAME)       sync_due = latch_d || sync_hit(cnt_inc(cnt_d));
        else                            sync_due = latch_d || sync_hit(cnt_d);
        offer_d = (slot_d == '0) && !sync_due && (st_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= S_IDLE;
            sh_q        <= '0;
            slot_q      <= '0;
            hw_q        <= '0;
            cnt_q       <= '0;
            latch_q     <= 1'b0;
            wsel_q      <= 2'd2;
            offer_q     <= 1'b0;
            traceDout   <= '0;
            traceClkOut <= 1'b0;
            inFrame     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            st_q        <= st_d;
            sh_q        <= sh_d;
            slot_q      <= slot_d;
            hw_q        <= hw_d;
            cnt_q       <= cnt_d;
            latch_q     <= latch_d;
            wsel_q      <= wsel_d;
            offer_q     <= offer_d;
            traceDout   <= dout_d;
            traceClkOut <= ~traceClkOut;
            inFrame     <= (st_d == S_FRAME);
            underrun    <= last && (st_d == S_INS);
        end
    end

    assign wd.WdTaken = offer_q & wd.WdAvail;
endmodule

// File: tb/tb_trace_tx.sv
// Bench for trace_tx: logs every slot, then compares against a pattern-level
// model of the trace stream rebuilt from the logged inputs.
module tb_trace_tx;
    localparam int SI      = 2;
    localparam int MAXC    = 1024;
    localparam int K_FSYNC = 0;
    localparam int K_HSYNC = 1;
    localparam int K_FRAME = 2;
    localparam int K_INS   = 3;

    logic       clk, rst, syncReq, traceClkOut, inFrame, underrun;
    logic [1:0] width;
    logic [3:0] traceDout;

    trace_tx_if wif();

    trace_tx #(.SYNC_INTERVAL(SI), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .width(width), .syncReq(syncReq), .wd(wif),
        .traceDout(traceDout), .traceClkOut(traceClkOut),
        .inFrame(inFrame), .underrun(underrun)
    );

    int ntests = 0;
    int nfail  = 0;
    int ntake, gap_after, gap_len, gap_left;
    logic [15:0] src_q[$];

    logic [3:0]  log_dout[MAXC];
    logic        log_tclk[MAXC], log_taken[MAXC], log_inf[MAXC], log_under[MAXC];
    logic        log_avail[MAXC], log_sreq[MAXC];
    logic [15:0] log_word[MAXC];
    logic [1:0]  log_width[MAXC];
    logic [3:0]  exp_dout[MAXC];
    logic        exp_taken[MAXC], exp_inf[MAXC], exp_under[MAXC];
    bit          sreq_at[MAXC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int wbits(input logic [1:0] w);
        return (w == 2'd0) ? 1 : ((w == 2'd1) ? 2 : 4);
    endfunction

    task automatic release_reset(input logic [1:0] w);
        rst = 1'b0;
        width = w;
        syncReq = 1'b0;
        wif.WdAvail = 1'b0;
        wif.PacketWd = 16'h0;
        ntake = 0; gap_after = 0; gap_len = 0; gap_left = 0;
        for (int c = 0; c < MAXC; c++) sreq_at[c] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One slot per iteration: drive after the edge, sample at the falling edge
    task automatic run_cycles(input int n, input int avail_pct, input int sreq_pct, input int wchg_pct);
        bit en;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (wchg_pct != 0 && $urandom_range(99) < wchg_pct) width = 2'($urandom_range(3));
            en = ($urandom_range(99) < avail_pct);
            if (gap_left > 0) begin en = 1'b0; gap_left--; end
            wif.WdAvail  = en && (src_q.size() != 0);
            wif.PacketWd = (src_q.size() != 0) ? src_q[0] : 16'($urandom);
            syncReq = sreq_at[c] || ($urandom_range(99) < sreq_pct);
            @(negedge clk);
            log_dout[c]  = traceDout;   log_tclk[c]  = traceClkOut;
            log_taken[c] = wif.WdTaken; log_inf[c]   = inFrame;
            log_under[c] = underrun;    log_avail[c] = wif.WdAvail;
            log_sreq[c]  = syncReq;     log_word[c]  = wif.PacketWd;
            log_width[c] = width;
            if (wif.WdAvail && wif.WdTaken) begin
                void'(src_q.pop_front());
                ntake++;
                if (ntake == gap_after) gap_left = gap_len;
            end
        end
    endtask

    // Pattern-by-pattern reconstruction of the expected stream
    task automatic build_model(input int n, input logic [1:0] w0);
        int t, len, d, wb, cnt, clr, left, kind;
        logic [31:0] pat;
        bit req;
        for (int c = 0; c < n; c++) begin
            exp_dout[c] = 4'h0; exp_taken[c] = 1'b0; exp_inf[c] = 1'b0; exp_under[c] = 1'b0;
        end
        t = 0; cnt = 0; clr = -1; left = 0; kind = K_FSYNC; wb = wbits(w0); pat = 32'h7FFF_FFFF;
        while (t < n) begin
            len = ((kind == K_FSYNC) ? 32 : 16) / wb;
            for (int i = 0; i < len; i++) begin
                if (t + i < n) begin
                    exp_dout[t+i]  = 4'((pat >> (i * wb)) & ((32'd1 << wb) - 32'd1));
                    exp_inf[t+i]   = (kind == K_FRAME);
                    exp_under[t+i] = (kind == K_INS) && (i == 0);
                end
            end
            d = t + len - 1;
            if (d >= n) break;
            if (kind == K_FSYNC) begin cnt = 0; clr = d; end
            if (kind == K_FRAME) begin
                left--;
                if (left == 0 && cnt < SI) cnt++;
            end
            if (left > 0) begin
                if (log_avail[d]) begin kind = K_FRAME; pat = {16'h0, log_word[d]}; exp_taken[d] = 1'b1; end
                else begin kind = K_INS; pat = 32'h7FFF; end
            end else begin
                req = 1'b0;
                for (int c = clr + 1; c < d; c++) req |= log_sreq[c];
                if (req || cnt == SI) begin
                    kind = K_FSYNC; pat = 32'h7FFF_FFFF; wb = wbits(log_width[d]);
                end else if (log_avail[d]) begin
                    kind = K_FRAME; left = 8; pat = {16'h0, log_word[d]}; exp_taken[d] = 1'b1;
                end else begin
                    kind = K_HSYNC; pat = 32'h7FFF;
                end
            end
            t = d + 1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] got, exp;
        rst = 1'b0; width = 2'd2; syncReq = 1'b0;
        wif.WdAvail = 1'b1; wif.PacketWd = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ntests++;
        got = {traceDout, traceClkOut, wif.WdTaken, inFrame, underrun};
        if (got !== 8'h00) begin nfail++; $display("FAIL reset_values: got %b exp 00000000", got); end
        src_q.delete();
        release_reset(2'd2);
        run_cycles(40, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            ntests++;
            if (log_dout[i] !== ((i == 7 || i == 11) ? 4'h7 : 4'hF)) begin
                nfail++; $display("FAIL reset_sync_nibble %0d: got %h", i, log_dout[i]); break;
            end
        end
        build_model(40, 2'd2);
        for (int c = 0; c < 40; c++) begin
            ntests++;
            got = {log_dout[c], log_tclk[c], log_taken[c], log_inf[c], log_under[c]};
            exp = {exp_dout[c], 1'(c % 2 == 0), exp_taken[c], exp_inf[c], exp_under[c]};
            if (got !== exp) begin nfail++; $display("FAIL reset_stream cycle %0d: got %b exp %b", c, got, exp); break; end
        end
    endtask

    task automatic test_frame_4bit();
        logic [7:0] got, exp;
        int nin;
        src_q = '{16'h3412, 16'h7856, 16'hBC9A, 16'hF0DE, 16'h1032, 16'h5476, 16'h98BA, 16'hDCFE};
        release_reset(2'd2);
        run_cycles(64, 100, 0, 0);
        nin = 0;
        for (int c = 0; c < 64; c++) nin += int'(log_inf[c]);
        ntests++;
        if (ntake !== 8 || nin !== 32) begin nfail++; $display("FAIL frame4_counts: takes %0d inframe %0d exp 8 32", ntake, nin); end
        ntests++;
        if ({log_inf[8], log_dout[8], log_dout[9], log_dout[10]} !== {1'b1, 12'h214}) begin
            nfail++; $display("FAIL frame4_first_nibbles: got %b %h %h %h", log_inf[8], log_dout[8], log_dout[9], log_dout[10]);
        end
        build_model(64, 2'd2);
        for (int c = 0; c < 64; c++) begin
            ntests++;
            got = {log_dout[c], log_tclk[c], log_taken[c], log_inf[c], log_under[c]};
            exp = {exp_dout[c], 1'(c % 2 == 0), exp_taken[c], exp_inf[c], exp_under[c]};
            if (got !== exp) begin nfail++; $display("FAIL frame4_stream cycle %0d: got %b exp %b", c, got, exp); break; end
        end
    endtask

    task automatic test_width1();
        logic [7:0] got, exp;
        src_q = '{16'h0001};
        for (int i = 0; i < 7; i++) src_q.push_back(16'($urandom));
        release_reset(2'd0);
        run_cycles(200, 100, 0, 0);
        for (int i = 0; i < 16; i++) begin
            ntests++;
            if (log_dout[32+i] !== ((i == 0) ? 4'h1 : 4'h0)) begin
                nfail++; $display("FAIL width1_word0 bit %0d: got %h", i, log_dout[32+i]); break;
            end
        end
        build_model(200, 2'd0);
        for (int c = 0; c < 200; c++) begin
            ntests++;
            got = {log_dout[c], log_tclk[c], log_taken[c], log_inf[c], log_under[c]};
            exp = {exp_dout[c], 1'(c % 2 == 0), exp_taken[c], exp_inf[c], exp_under[c]};
            if (got !== exp || log_dout[c][3:1] !== 3'b000) begin
                nfail++; $display("FAIL width1_stream cycle %0d: got %b exp %b", c, got, exp); break;
            end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] got, exp;
        int nund, ucyc;
        src_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(16'($urandom));
        release_reset(2'd2);
        gap_after = 3; gap_len = 6;
        run_cycles(80, 100, 0, 0);
        nund = 0; ucyc = -1;
        for (int c = 0; c < 80; c++) if (log_under[c]) begin nund++; if (ucyc < 0) ucyc = c; end
        ntests++;
        if (nund !== 1 || ntake !== 8 || ucyc !== 20) begin
            nfail++; $display("FAIL underrun_counts: pulses %0d takes %0d at %0d exp 1 8 20", nund, ntake, ucyc);
        end
        ntests++;
        if (ucyc >= 0 && {log_dout[ucyc], log_dout[ucyc+3], log_inf[ucyc], log_inf[ucyc+4]} !== {4'hF, 4'h7, 1'b0, 1'b1}) begin
            nfail++; $display("FAIL underrun_insert: got %h %h %b %b", log_dout[ucyc], log_dout[ucyc+3], log_inf[ucyc], log_inf[ucyc+4]);
        end
        build_model(80, 2'd2);
        for (int c = 0; c < 80; c++) begin
            ntests++;
            got = {log_dout[c], log_tclk[c], log_taken[c], log_inf[c], log_under[c]};
            exp = {exp_dout[c], 1'(c % 2 == 0), exp_taken[c], exp_inf[c], exp_under[c]};
            if (got !== exp) begin nfail++; $display("FAIL underrun_stream cycle %0d: got %b exp %b", c, got, exp); break; end
        end
    endtask

    task automatic test_sync_interval();
        logic [7:0] got, exp;
        src_q.delete();
        for (int i = 0; i < 60; i++) src_q.push_back(16'($urandom));
        release_reset(2'd2);
        sreq_at[3] = 1'b1;
        sreq_at[90] = 1'b1;
        run_cycles(200, 100, 0, 0);
        ntests++;
        if ({log_inf[8], log_inf[72], log_dout[72], log_dout[79], log_inf[80]} !== {1'b1, 1'b0, 4'hF, 4'h7, 1'b1}) begin
            nfail++; $display("FAIL sync_interval_periodic: got %b %b %h %h %b", log_inf[8], log_inf[72], log_dout[72], log_dout[79], log_inf[80]);
        end
        ntests++;
        if ({log_inf[111], log_inf[112], log_dout[119], log_inf[120], log_inf[184], log_dout[191]} !== {1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 4'h7}) begin
            nfail++; $display("FAIL sync_request: got %b %b %h %b %b %h", log_inf[111], log_inf[112], log_dout[119], log_inf[120], log_inf[184], log_dout[191]);
        end
        build_model(200, 2'd2);
        for (int c = 0; c < 200; c++) begin
            ntests++;
            got = {log_dout[c], log_tclk[c], log_taken[c], log_inf[c], log_under[c]};
            exp = {exp_dout[c], 1'(c % 2 == 0), exp_taken[c], exp_inf[c], exp_under[c]};
            if (got !== exp) begin nfail++; $display("FAIL sync_stream cycle %0d: got %b exp %b", c, got, exp); break; end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] got, exp;
        src_q.delete();
        for (int i = 0; i < 40; i++) src_q.push_back(16'($urandom));
        release_reset(2'd2);
        run_cycles(13, 100, 0, 0);
        ntests++;
        if ({log_inf[7], log_inf[8], log_inf[12]} !== 3'b011) begin
            nfail++; $display("FAIL async_pre_slot5: got %b exp 011", {log_inf[7], log_inf[8], log_inf[12]});
        end
        #2 rst = 1'b0;
        wif.WdAvail = 1'b1;
        #1;
        ntests++;
        got = {traceDout, traceClkOut, wif.WdTaken, inFrame, underrun};
        if (got !== 8'h00) begin nfail++; $display("FAIL async_reset_values: got %b exp 00000000", got); end
        width = 2'd1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_cycles(80, 100, 0, 0);
        ntests++;
        if ({log_dout[0], log_dout[14], log_dout[15], log_inf[15], log_inf[16]} !== {4'h3, 4'h3, 4'h1, 1'b0, 1'b1}) begin
            nfail++; $display("FAIL async_restart_fsync: got %h %h %h %b %b", log_dout[0], log_dout[14], log_dout[15], log_inf[15], log_inf[16]);
        end
        build_model(80, 2'd1);
        for (int c = 0; c < 80; c++) begin
            ntests++;
            got = {log_dout[c], log_tclk[c], log_taken[c], log_inf[c], log_under[c]};
            exp = {exp_dout[c], 1'(c % 2 == 0), exp_taken[c], exp_inf[c], exp_under[c]};
            if (got !== exp) begin nfail++; $display("FAIL async_stream cycle %0d: got %b exp %b", c, got, exp); break; end
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        logic [1:0] w0;
        for (int r = 0; r < 2; r++) begin
            src_q.delete();
            for (int i = 0; i < 500; i++) src_q.push_back(16'($urandom));
            w0 = 2'($urandom_range(3));
            release_reset(w0);
            run_cycles(1000, 85, 2, 1);
            build_model(1000, w0);
            for (int c = 0; c < 1000; c++) begin
                ntests++;
                got = {log_dout[c], log_tclk[c], log_taken[c], log_inf[c], log_under[c]};
                exp = {exp_dout[c], 1'(c % 2 == 0), exp_taken[c], exp_inf[c], exp_under[c]};
                if (got !== exp) begin nfail++; $display("FAIL random%0d_stream cycle %0d: got %b exp %b", r, c, got, exp); break; end
            end
        end
    endtask

    initial begin
        rst = 1'b0; width = 2'd2; syncReq = 1'b0;
        wif.WdAvail = 1'b0; wif.PacketWd = 16'h0;
        test_reset();
        test_frame_4bit();
        test_width1();
        test_underrun();
        test_sync_interval();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
